// File: rtl/fft_pkg.sv
// Shared definitions for the FFT back-end: magnitude approximation selectors.
package fft_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LEGACY = 2'd0,
    MODE_HALF   = 2'd1,
    MODE_1516   = 2'd2,
    MODE_MAX78  = 2'd3
  } mag_mode_e;

endpackage

// File: rtl/mag_peak_tracker.sv
// Tracks the largest magnitude of the current frame and publishes it on the last bin.
module mag_peak_tracker #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned BIN_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 hs,
  input  logic [WORD_SIZE-1:0] mg,
  input  logic [BIN_W-1:0]     bin,
  input  logic                 last,
  input  logic                 trunc,
  output logic                 peak_valid,
  output logic [WORD_SIZE-1:0] peak_mg,
  output logic [BIN_W-1:0]     peak_bin
);

  logic [WORD_SIZE-1:0] run_mg;
  logic [BIN_W-1:0]     run_bin;
  logic [WORD_SIZE-1:0] cur_mg;
  logic [BIN_W-1:0]     cur_bin;
  logic                 load;

  // Bin 0 (or a realigning sop) restarts the frame; otherwise strictly greater wins.
  always_comb begin
    load    = (bin == '0) | trunc | (mg > run_mg);
    cur_mg  = load ? mg  : run_mg;
    cur_bin = load ? bin : run_bin;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_mg     <= '0;
      run_bin    <= '0;
      peak_valid <= 1'b0;
      peak_mg    <= '0;
      peak_bin   <= '0;
    end else begin
      peak_valid <= hs & last;
      if (hs) begin
        run_mg  <= cur_mg;
        run_bin <= cur_bin;
      end
      if (hs && last) begin
        peak_mg  <= cur_mg;
        peak_bin <= cur_bin;
      end
    end
  end

endmodule

// File: rtl/magnitude_stream.sv
// Streaming complex-magnitude estimator (alpha-max-plus-beta-min), 3-stage pipeline
// with bin tagging and per-frame peak reporting.
module magnitude_stream
  import fft_pkg::*;
#(
  parameter  int unsigned WORD_SIZE = 16,
  parameter  int unsigned FRAME_LEN = 256,
  localparam int unsigned BIN_W     = $clog2(FRAME_LEN)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WORD_SIZE-1:0] in_re,
  input  logic signed [WORD_SIZE-1:0] in_im,
  input  logic                        in_sop,
  input  logic [MODE_W-1:0]           mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_SIZE-1:0]        out_mg,
  output logic [BIN_W-1:0]            out_bin,
  output logic                        out_last,
  output logic                        peak_valid,
  output logic [WORD_SIZE-1:0]        peak_mg,
  output logic [BIN_W-1:0]            peak_bin
);

  localparam int unsigned XW = WORD_SIZE + 1;
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FRAME_LEN - 1);

  function automatic logic [WORD_SIZE-1:0] abs_w(input logic [WORD_SIZE-1:0] x);
    return x[WORD_SIZE-1] ? (~x + WORD_SIZE'(1)) : x;
  endfunction

  logic                 en;
  logic                 accept;
  logic [BIN_W-1:0]     cnt;
  logic [BIN_W-1:0]     in_bin;
  logic [BIN_W-1:0]     cnt_nxt;

  logic                 s1_valid;
  logic [WORD_SIZE-1:0] s1_re_abs;
  logic [WORD_SIZE-1:0] s1_im_abs;
  mag_mode_e            s1_mode;
  logic [BIN_W-1:0]     s1_bin;
  logic                 s1_trunc;

  logic                 s2_valid;
  logic [WORD_SIZE-1:0] s2_max;
  logic [WORD_SIZE-1:0] s2_min;
  mag_mode_e            s2_mode;
  logic [BIN_W-1:0]     s2_bin;
  logic                 s2_trunc;

  logic                 out_trunc;
  logic [XW-1:0]        mx;
  logic [XW-1:0]        mn;
  logic [XW-1:0]        m78;
  logic [WORD_SIZE-1:0] comb_mg;

  // Whole pipeline advances together; bubbles are kept while stalled.
  assign en       = !out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  always_comb begin
    in_bin  = in_sop ? '0 : cnt;
    cnt_nxt = (in_bin == LAST_BIN) ? '0 : in_bin + BIN_W'(1);
  end

  // S1: absolute values plus sideband tagging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_re_abs <= '0;
      s1_im_abs <= '0;
      s1_mode   <= MODE_LEGACY;
      s1_bin    <= '0;
      s1_trunc  <= 1'b0;
    end else begin
      if (accept) cnt <= cnt_nxt;
      if (en) begin
        s1_valid  <= accept;
        s1_re_abs <= abs_w(in_re);
        s1_im_abs <= abs_w(in_im);
        s1_mode   <= mag_mode_e'(mode);
        s1_bin    <= in_bin;
        s1_trunc  <= in_sop & (cnt != '0);
      end
    end
  end

  // S2: order the two magnitudes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_max   <= '0;
      s2_min   <= '0;
      s2_mode  <= MODE_LEGACY;
      s2_bin   <= '0;
      s2_trunc <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_max   <= (s1_re_abs >= s1_im_abs) ? s1_re_abs : s1_im_abs;
      s2_min   <= (s1_re_abs >= s1_im_abs) ? s1_im_abs : s1_re_abs;
      s2_mode  <= s1_mode;
      s2_bin   <= s1_bin;
      s2_trunc <= s1_trunc;
    end
  end

  // S3 combine, one bit of headroom so max+min of two full-scale values cannot wrap.
  always_comb begin
    mx      = XW'(s2_max);
    mn      = XW'(s2_min);
    m78     = mx - (mx >> 3) + (mn >> 1);
    comb_mg = '0;
    case (s2_mode)
      MODE_LEGACY: comb_mg = WORD_SIZE'((mx + mn) >> 2);
      MODE_HALF:   comb_mg = WORD_SIZE'(mx + (mn >> 1));
      MODE_1516:   comb_mg = WORD_SIZE'(mx - (mx >> 4) + (mn >> 1) - (mn >> 5));
      MODE_MAX78:  comb_mg = WORD_SIZE'((m78 > mx) ? m78 : mx);
      default:     comb_mg = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_mg    <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      out_trunc <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_mg    <= comb_mg;
      out_bin   <= s2_bin;
      out_last  <= s2_valid & (s2_bin == LAST_BIN);
      out_trunc <= s2_valid & s2_trunc;
    end
  end

  mag_peak_tracker #(
    .WORD_SIZE (WORD_SIZE),
    .BIN_W     (BIN_W)
  ) u_peak (
    .clk        (clk),
    .reset_n    (reset_n),
    .hs         (out_valid & out_ready),
    .mg         (out_mg),
    .bin        (out_bin),
    .last       (out_last),
    .trunc      (out_trunc),
    .peak_valid (peak_valid),
    .peak_mg    (peak_mg),
    .peak_bin   (peak_bin)
  );

endmodule

// File: tb/tb_magnitude_stream.sv
// Scoreboard bench for magnitude_stream with an 8-bin frame.
module tb_magnitude_stream;

  localparam int W  = 16;
  localparam int FL = 8;
  localparam int BW = 3;

  logic                clk;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                in_sop;
  logic [1:0]          in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_mg;
  logic [BW-1:0]       out_bin;
  logic                out_last;
  logic                peak_valid;
  logic [W-1:0]        peak_mg;
  logic [BW-1:0]       peak_bin;

  typedef struct {
    logic [W-1:0]  mg;
    logic [BW-1:0] bin;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t peak_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tb_cnt = 0;

  magnitude_stream #(.WORD_SIZE(W), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_sop     (in_sop),
    .mode       (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mg     (out_mg),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .peak_valid (peak_valid),
    .peak_mg    (peak_mg),
    .peak_bin   (peak_bin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record output handshakes and peak pulses away from the active edge.
  always @(negedge clk) begin
    beat_t b;
    if (reset_n && out_valid && out_ready) begin
      b.mg = out_mg; b.bin = out_bin; b.last = out_last; b.cyc = cyc;
      got_q.push_back(b);
    end
    if (reset_n && peak_valid) begin
      b.mg = peak_mg; b.bin = peak_bin; b.last = 1'b1; b.cyc = cyc;
      peak_q.push_back(b);
    end
  end

  function automatic logic [W-1:0] model(input int re, input int im, input int md);
    int a, b, mx, mn, r;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    case (md)
      0: r = (mx + mn) / 4;
      1: r = mx + mn / 2;
      2: r = mx - mx / 16 + mn / 2 - mn / 32;
      default: begin
        r = mx - mx / 8 + mn / 2;
        if (r < mx) r = mx;
      end
    endcase
    return W'(r);
  endfunction

  // Drive one beat and push its expectation when the handshake is seen.
  task automatic send(input int re, input int im, input int md, input bit sop, input int exp_mg);
    beat_t e;
    int n = 0;
    int bin;
    in_re = W'(re); in_im = W'(im); in_mode = 2'(md); in_sop = sop; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      in_valid = 1'b0; in_sop = 1'b0;
      return;
    end
    bin = sop ? 0 : tb_cnt;
    tb_cnt = (bin == FL - 1) ? 0 : bin + 1;
    e.mg = W'(exp_mg); e.bin = BW'(bin); e.last = (bin == FL - 1); e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({out_valid, out_mg, out_bin, out_last, peak_valid, peak_mg, peak_bin} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b mg=%0d bin=%0d last=%0b pv=%0b pmg=%0d pbin=%0d, want all 0",
               out_valid, out_mg, out_bin, out_last, peak_valid, peak_mg, peak_bin);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset: got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    beat_t e, g;
    send(-32768, -32768, 0, 1'b0, 16384);
    send(3, -4, 1, 1'b0, 5);
    send(1600, 800, 2, 1'b0, 1875);
    send(1000, 0, 3, 1'b0, 1000);
    send(1000, 1000, 3, 1'b0, 1375);
    for (int i = 0; i < 8; i++) begin
      int re, im, md;
      re = int'($urandom_range(65535)) - 32768;
      im = int'($urandom_range(65535)) - 32768;
      md = int'($urandom_range(3));
      send(re, im, md, 1'b0, model(re, im, md));
    end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL modes_missing: got none, want mg=%0d bin=%0d", e.mg, e.bin);
      end else begin
        g = got_q.pop_front();
        if (g.mg !== e.mg || g.bin !== e.bin || g.last !== e.last) begin
          bad++;
          $display("FAIL modes_data: got mg=%0d bin=%0d last=%0b, want mg=%0d bin=%0d last=%0b",
                   g.mg, g.bin, g.last, e.mg, e.bin, e.last);
        end
        total++;
        if (g.cyc - e.cyc != 3) begin
          bad++; $display("FAIL modes_latency: got %0d cycles, want 3", g.cyc - e.cyc);
        end
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL modes_extra: got %0d extra, want 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e, g;
    send(8, 8, 0, 1'b0, 4);
    send(8, 8, 1, 1'b0, 12);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL b2b_missing: got none, want mg=%0d", e.mg);
      end else begin
        g = got_q.pop_front();
        if (g.mg !== e.mg || g.bin !== e.bin) begin
          bad++; $display("FAIL b2b_data: got mg=%0d bin=%0d, want mg=%0d bin=%0d", g.mg, g.bin, e.mg, e.bin);
        end
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra, want 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_stall();
    beat_t e, g;
    int prev_cyc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(1000 + 37 * i, -5 * i, 1, 1'b0, model(1000 + 37 * i, -5 * i, 1));
      end
      begin
        int n = 0;
        logic [W-1:0] held_mg;
        logic [BW-1:0] held_bin;
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        held_mg = out_mg; held_bin = out_bin;
        repeat (5) begin
          @(negedge clk);
          total++;
          if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %0b want 0", in_ready); end
          total++;
          if (out_valid !== 1'b1 || out_mg !== held_mg || out_bin !== held_bin) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b mg=%0d bin=%0d, want v=1 mg=%0d bin=%0d",
                     out_valid, out_mg, out_bin, held_mg, held_bin);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL stall_missing: got none, want mg=%0d", e.mg);
      end else begin
        g = got_q.pop_front();
        if (g.mg !== e.mg || g.bin !== e.bin) begin
          bad++; $display("FAIL stall_data: got mg=%0d bin=%0d, want mg=%0d bin=%0d", g.mg, g.bin, e.mg, e.bin);
        end
        if (i > 0) begin
          total++;
          if (g.cyc - prev_cyc != 1) begin
            bad++; $display("FAIL stall_rate: got gap %0d, want 1", g.cyc - prev_cyc);
          end
        end
        prev_cyc = g.cyc;
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL stall_extra: got %0d extra, want 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_frame_peak();
    beat_t e, g, p;
    int mags[8] = '{5, 9, 2, 9, 1, 0, 3, 7};
    int last_cyc = -100;
    peak_q.delete();
    for (int i = 0; i < 8; i++) send(mags[i], 0, 1, (i == 0), mags[i]);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL frame_missing: got none, want mg=%0d", e.mg);
      end else begin
        g = got_q.pop_front();
        if (g.mg !== e.mg || g.bin !== e.bin || g.last !== e.last) begin
          bad++;
          $display("FAIL frame_data: got mg=%0d bin=%0d last=%0b, want mg=%0d bin=%0d last=%0b",
                   g.mg, g.bin, g.last, e.mg, e.bin, e.last);
        end
        if (g.last) last_cyc = g.cyc;
      end
    end
    got_q.delete();
    total++;
    if (peak_q.size() != 1) begin
      bad++; $display("FAIL frame_peak_count: got %0d pulses, want 1", peak_q.size());
    end else begin
      p = peak_q.pop_front();
      total++;
      if (p.mg !== 16'd9 || p.bin !== 3'd1) begin
        bad++; $display("FAIL frame_peak_value: got mg=%0d bin=%0d, want mg=9 bin=1", p.mg, p.bin);
      end
      total++;
      if (p.cyc != last_cyc + 1) begin
        bad++; $display("FAIL frame_peak_timing: got cycle %0d, want %0d", p.cyc, last_cyc + 1);
      end
    end
    total++;
    if (peak_mg !== 16'd9 || peak_bin !== 3'd1) begin
      bad++; $display("FAIL frame_peak_hold: got mg=%0d bin=%0d, want 9/1", peak_mg, peak_bin);
    end
  endtask

  task automatic test_truncated();
    beat_t e, g, p;
    int trunc_mags[4] = '{100, 200, 150, 120};
    int full_mags[8]  = '{10, 40, 40, 20, 30, 5, 1, 2};
    int lasts = 0;
    peak_q.delete();
    for (int i = 0; i < 4; i++) send(trunc_mags[i], 0, 1, (i == 0), trunc_mags[i]);
    for (int i = 0; i < 8; i++) send(0, full_mags[i], 1, (i == 0), full_mags[i]);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL trunc_missing: got none, want mg=%0d", e.mg);
      end else begin
        g = got_q.pop_front();
        if (g.mg !== e.mg || g.bin !== e.bin || g.last !== e.last) begin
          bad++;
          $display("FAIL trunc_data: got mg=%0d bin=%0d last=%0b, want mg=%0d bin=%0d last=%0b",
                   g.mg, g.bin, g.last, e.mg, e.bin, e.last);
        end
        if (g.last) lasts++;
      end
    end
    got_q.delete();
    total++;
    if (lasts != 1) begin bad++; $display("FAIL trunc_last_count: got %0d, want 1", lasts); end
    total++;
    if (peak_q.size() != 1) begin
      bad++; $display("FAIL trunc_peak_count: got %0d pulses, want 1", peak_q.size());
    end else begin
      p = peak_q.pop_front();
      total++;
      if (p.mg !== 16'd40 || p.bin !== 3'd1) begin
        bad++; $display("FAIL trunc_peak_value: got mg=%0d bin=%0d, want mg=40 bin=1", p.mg, p.bin);
      end
    end
  endtask

  task automatic test_reset_midframe();
    beat_t g;
    send(50, 60, 1, 1'b0, model(50, 60, 1));
    send(70, 80, 1, 1'b0, model(70, 80, 1));
    send(90, 10, 1, 1'b0, model(90, 10, 1));
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, out_mg, out_bin, out_last, peak_valid, peak_mg, peak_bin} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%0b mg=%0d bin=%0d last=%0b pv=%0b pmg=%0d pbin=%0d, want all 0",
               out_valid, out_mg, out_bin, out_last, peak_valid, peak_mg, peak_bin);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready: got %0b want 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete(); got_q.delete(); peak_q.delete();
    tb_cnt = 0;
    send(300, 400, 1, 1'b0, 550);
    wait_drain();
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL midreset_count: got %0d outputs, want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      total++;
      if (g.mg !== 16'd550 || g.bin !== 3'd0) begin
        bad++; $display("FAIL midreset_first: got mg=%0d bin=%0d, want mg=550 bin=0", g.mg, g.bin);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
    in_sop = 1'b0; in_mode = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_frame_peak();
    test_truncated();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
